// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one magnitude comparator among NREQ requesters.
// Each transaction latches the winner's operands, samples the comparator result, and returns it over a valid/ready handshake.
module cmp_share_arbiter #(
    parameter  int NREQ = 4,
    parameter  int W    = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_bus,
    input  logic [NREQ*W-1:0] b_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      cmp_a,
    output logic [W-1:0]      cmp_b,
    input  logic [3:0]        cmp_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_lt,
    output logic              rsp_eq,
    output logic              rsp_gt,
    output logic              rsp_err,
    output logic [7:0]        txn_cnt
);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    idx_q, idx_d;
    logic [IDW-1:0]    pick_idx;
    logic [NREQ-1:0]   gnt_d;
    logic [W-1:0]      cmp_a_d, cmp_b_d;
    logic              rsp_valid_d, rsp_lt_d, rsp_eq_d, rsp_gt_d, rsp_err_d;
    logic [IDW-1:0]    rsp_id_d;
    logic [7:0]        txn_cnt_d;

    // Bit 3 of the comparator result is a floating pin and carries no information.
    logic cmp_r_unused;
    assign cmp_r_unused = cmp_r[3];

    function automatic logic [IDW-1:0] rr_slot(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Walking from the farthest slot back to rr_ptr leaves the nearest requester as the final pick.
    always_comb begin
        pick_idx = rr_ptr_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[rr_slot(rr_ptr_q, i)]) pick_idx = rr_slot(rr_ptr_q, i);
        end
    end

    // NOTE: Every signal assigned in this block first gets a default (hold or clear). This prevents latch inference when a case arm leaves a signal unassigned.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        gnt_d       = '0;
        cmp_a_d     = cmp_a;
        cmp_b_d     = cmp_b;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_lt_d    = rsp_lt;
        rsp_eq_d    = rsp_eq;
        rsp_gt_d    = rsp_gt;
        rsp_err_d   = rsp_err;
        txn_cnt_d   = txn_cnt;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d           = pick_idx;
                    cmp_a_d         = a_bus[int'(pick_idx)*W +: W];
                    cmp_b_d         = b_bus[int'(pick_idx)*W +: W];
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = CMP;
                end
            end
            CMP: begin
                rsp_lt_d    = cmp_r[0];
                rsp_eq_d    = cmp_r[1];
                rsp_gt_d    = cmp_r[2];
                rsp_id_d    = idx_q;
                rsp_valid_d = 1'b1;
                case (cmp_r[2:0])
                    3'b001, 3'b010, 3'b100: rsp_err_d = 1'b0;
                    default:                rsp_err_d = 1'b1;
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_cnt_d   = txn_cnt + 8'd1;
                    rr_ptr_d    = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: Sequential state uses non-blocking assignments. Every flop then samples values from before the clock edge, whatever order the statements run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            cmp_a     <= '0;
            cmp_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_lt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_err   <= 1'b0;
            txn_cnt   <= '0;
        end else begin
            gnt       <= gnt_d;
            cmp_a     <= cmp_a_d;
            cmp_b     <= cmp_b_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_lt    <= rsp_lt_d;
            rsp_eq    <= rsp_eq_d;
            rsp_gt    <= rsp_gt_d;
            rsp_err   <= rsp_err_d;
            txn_cnt   <= txn_cnt_d;
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter. A behavioural comparator sits on cmp_a/cmp_b, and directed steps drive the inputs.
// Expected responses go into a scoreboard queue at request time and are checked against each response.
module tb_cmp_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_bus = '0;
    logic [NREQ*W-1:0] b_bus = '0;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      cmp_a, cmp_b;
    logic [3:0]        cmp_r;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_lt, rsp_eq, rsp_gt, rsp_err;
    logic [7:0]        txn_cnt;

    logic              force_en = 1'b0;
    logic [3:0]        force_r = '0;

    typedef struct {
        int id;
        bit lt;
        bit eq;
        bit gt;
        bit err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt = 0;
    int   exp_ptr = 0;

    always #5 clk = ~clk;

    // Shared comparator model, with an override to inject corrupted results.
    assign cmp_r = force_en ? force_r : {1'b0, cmp_a > cmp_b, cmp_a == cmp_b, cmp_a < cmp_b};

    cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_r(cmp_r),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_err(rsp_err),
        .txn_cnt(txn_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] rq, input int exp_id, input bit keep_req,
                           input int stall, input bit mutate);
        exp_t       e, got;
        logic [W-1:0] ea, eb;
        logic [3:0] r;
        bit         seen;
        ea = a_bus[exp_id*W +: W];
        eb = b_bus[exp_id*W +: W];
        r  = force_en ? force_r : {1'b0, ea > eb, ea == eb, ea < eb};
        e.id  = exp_id;
        e.lt  = r[0];
        e.eq  = r[1];
        e.gt  = r[2];
        e.err = !(r[2:0] == 3'b001 || r[2:0] == 3'b010 || r[2:0] == 3'b100);
        sb.push_back(e);
        req  = rq;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (gnt != '0) seen = 1'b1;
        end
        check("gnt_seen", 32'(seen), 32'd1);
        if (!seen) begin
            got = sb.pop_back();
            req = '0;
            return;
        end
        check("gnt_onehot", 32'(gnt), 32'd1 << exp_id);
        check("cmp_a_latched", 32'(cmp_a), 32'(ea));
        check("cmp_b_latched", 32'(cmp_b), 32'(eb));
        check("valid_low_in_cmp", 32'(rsp_valid), 32'd0);
        if (!keep_req) req = '0;
        if (mutate) a_bus[exp_id*W +: W] = ~ea;
        tick();
        check("gnt_pulse_cleared", 32'(gnt), 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        got = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(got.id));
        check("rsp_flags", {28'd0, rsp_lt, rsp_eq, rsp_gt, rsp_err}, {28'd0, got.lt, got.eq, got.gt, got.err});
        if (mutate) check("cmp_a_after_bus_change", 32'(cmp_a), 32'(ea));
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_hold", {25'd0, rsp_id, rsp_lt, rsp_eq, rsp_gt, rsp_err},
                  {25'd0, 2'(got.id), got.lt, got.eq, got.gt, got.err});
            check("stall_no_gnt", 32'(gnt), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        exp_ptr = (exp_id + 1) % NREQ;
        check("valid_dropped", 32'(rsp_valid), 32'd0);
        check("txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_outs", {8'd0, cmp_a, cmp_b, 7'd0, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt, rsp_err},
              32'd0);
        check("reset_txn_cnt", 32'(txn_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: 3 vs 9 -> lt.
        a_bus = {4'd7, 4'd2, 4'd5, 4'd3};
        b_bus = {4'd1, 4'd2, 4'd8, 4'd9};
        run_txn(4'b0001, 0, 1'b0, 0, 1'b0);

        // Reset during RESP: rr_ptr is now 1, so req2 wins, then reset aborts it.
        req = 4'b0100;
        tick();
        check("pre_reset_gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_gnt", 32'(gnt), 32'd0);
        check("async_reset_outs", {8'd0, cmp_a, cmp_b, 7'd0, rsp_valid, rsp_id, rsp_lt, rsp_eq, rsp_gt, rsp_err},
              32'd0);
        check("async_reset_txn_cnt", 32'(txn_cnt), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = 0;
        exp_ptr = 0;

        // Round robin with all requests held high: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) run_txn(4'b1111, k % NREQ, 1'b1, 0, 1'b0);

        // Backpressure for 10 cycles with every requester still asking.
        run_txn(4'b1111, exp_ptr, 1'b1, 10, 1'b0);
        req = '0;

        // Corrupted comparator results; bit 3 must be ignored.
        force_en = 1'b1;
        force_r  = 4'b0110;
        run_txn(4'b0100, 2, 1'b0, 0, 1'b0);
        force_r  = 4'b1010;
        run_txn(4'b0001, 0, 1'b0, 0, 1'b0);
        force_r  = 4'b1000;
        run_txn(4'b1000, 3, 1'b0, 1, 1'b0);
        force_en = 1'b0;

        // Circular search: ptr=0 -> req 0101 picks 0, then ptr=1 picks 2, then ptr=3 with req 0010 picks 1.
        run_txn(4'b0101, 0, 1'b0, 0, 1'b0);
        run_txn(4'b0101, 2, 1'b0, 0, 1'b0);
        run_txn(4'b0010, 1, 1'b0, 0, 1'b0);

        // Operand bus changes after grant must not disturb the in-flight compare.
        run_txn(4'b1000, 3, 1'b0, 2, 1'b1);

        // Counter wrap 255 -> 0 with random operands.
        while (exp_cnt != 255) begin
            a_bus = NREQ*W'($urandom);
            b_bus = NREQ*W'($urandom);
            run_txn(4'b1111, exp_ptr, 1'b1, 0, 1'b0);
        end
        check("txn_cnt_at_255", 32'(txn_cnt), 32'd255);
        a_bus = NREQ*W'($urandom);
        b_bus = NREQ*W'($urandom);
        run_txn(4'b1111, exp_ptr, 1'b0, 0, 1'b0);
        check("txn_cnt_wrapped", 32'(txn_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
